// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : useq_pkg
// Brief   : Shared field layout, default sizes and reset microcode for the
//           micro-sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package useq_pkg;

  localparam int c_def_aw = 3;
  localparam int c_def_cw = 3;
  localparam int c_def_sw = 2;

  // Field positions (LSB index) for a word laid out as {sel, addr_a, addr_b, ctrl}
  function automatic int ctrl_lsb();
    return 0;
  endfunction

  function automatic int addr_b_lsb(input int cw);
    return cw;
  endfunction

  function automatic int addr_a_lsb(input int aw, input int cw);
    return cw + aw;
  endfunction

  function automatic int sel_lsb(input int aw, input int cw);
    return cw + 2 * aw;
  endfunction

  function automatic logic [63:0] field_mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] build_word(
    input int          aw,
    input int          cw,
    input int          sw,
    input logic [63:0] sel,
    input logic [63:0] addr_a,
    input logic [63:0] addr_b,
    input logic [63:0] ctrl
  );
    return ((sel    & field_mask(sw)) << sel_lsb(aw, cw))
         | ((addr_a & field_mask(aw)) << addr_a_lsb(aw, cw))
         | ((addr_b & field_mask(aw)) << addr_b_lsb(cw))
         | ((ctrl   & field_mask(cw)) << ctrl_lsb());
  endfunction

  // Boot microprogram; only defined for the default geometry, zero otherwise.
  function automatic logic [63:0] default_ucode(
    input int aw,
    input int cw,
    input int sw,
    input int idx
  );
    logic [63:0] w;
    w = 64'd0;
    if (aw == c_def_aw && cw == c_def_cw && sw == c_def_sw) begin
      case (idx)
        0:       w = build_word(aw, cw, sw, 64'd0, 64'd0, 64'd1, 64'd0);
        1:       w = build_word(aw, cw, sw, 64'd3, 64'd2, 64'd2, 64'd4);
        2:       w = build_word(aw, cw, sw, 64'd1, 64'd3, 64'd0, 64'd0);
        3:       w = build_word(aw, cw, sw, 64'd2, 64'd2, 64'd4, 64'd1);
        4:       w = build_word(aw, cw, sw, 64'd3, 64'd2, 64'd2, 64'd2);
        default: w = 64'd0;
      endcase
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/useq_store.sv
`default_nettype none
// ============================================================================
// Module  : useq_store
// Brief   : Control store: register array, one sync write port, one comb read.
// Revision: 1.0 - initial release
// ============================================================================
module useq_store
  import useq_pkg::*;
#(
  parameter int AW = c_def_aw,
  parameter int CW = c_def_cw,
  parameter int SW = c_def_sw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [SW+2*AW+CW-1:0]  wdata,
  input  logic [AW-1:0]          raddr,
  output logic [SW+2*AW+CW-1:0]  rdata
);

  localparam int WW    = SW + 2 * AW + CW;
  localparam int DEPTH = 2 ** AW;

  logic [WW-1:0] w_def [DEPTH];
  logic [WW-1:0] r_mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_default
    assign w_def[i] = WW'(default_ucode(AW, CW, SW, i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_def[i];
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : micro_sequencer
// Brief   : Two-way branching micro-sequencer with writable control store.
// Revision: 1.0 - initial release
// ============================================================================
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int AW = c_def_aw,
  parameter int CW = c_def_cw,
  parameter int SW = c_def_sw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic [2**SW-2:0]       cond,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [SW+2*AW+CW-1:0]  wr_data,
  output logic [AW-1:0]          upc,
  output logic [CW-1:0]          ctrl,
  output logic                   taken,
  output logic                   halted,
  output logic                   wr_err
);

  localparam int WW = SW + 2 * AW + CW;

  logic [AW-1:0]    r_upc;
  logic             r_wr_err;
  logic [WW-1:0]    w_word;
  logic [SW-1:0]    w_sel;
  logic [AW-1:0]    w_addr_a;
  logic [AW-1:0]    w_addr_b;
  logic [2**SW-1:0] w_cond_ext;
  logic             w_taken;
  logic [AW-1:0]    w_next;
  logic             w_adv;
  logic             w_wr_ok;

  assign w_adv   = run | step;
  assign w_wr_ok = wr_en & ~w_adv;

  useq_store #(
    .AW (AW),
    .CW (CW),
    .SW (SW)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (r_upc),
    .rdata (w_word)
  );

  assign w_sel    = w_word[sel_lsb(AW, CW)    +: SW];
  assign w_addr_a = w_word[addr_a_lsb(AW, CW) +: AW];
  assign w_addr_b = w_word[addr_b_lsb(CW)     +: AW];

  // Slot 0 is tied low so sel=0 never branches and sel=k lands on cond[k-1].
  assign w_cond_ext = {cond, 1'b0};
  assign w_taken    = w_cond_ext[w_sel];
  assign w_next     = w_taken ? w_addr_a : w_addr_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upc <= '0;
    end else if (w_adv) begin
      r_upc <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en & w_adv;
    end
  end

  assign upc    = r_upc;
  assign ctrl   = w_word[ctrl_lsb() +: CW];
  assign taken  = w_taken;
  assign halted = (w_sel == '0) && (w_addr_b == r_upc);
  assign wr_err = r_wr_err;

endmodule
`default_nettype wire
